// File: rtl/move_cmd_gen.sv
// move_cmd_gen: turns a move command plus the heading stream into moving/err_vld/error/frwrd
// for the PID. Define MOVE_CMD_FAST_SIM_EN for coarse ramp steps in full-chip sims.
module move_cmd_gen #(
  parameter logic [11:0] ERR_TOL   = 12'h030,
  parameter logic [9:0]  FRWRD_INC = 10'h010,
  parameter logic [9:0]  FRWRD_MAX = 10'h300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  output logic        moving,
  output logic        err_vld,
  output logic [11:0] error,
  output logic [9:0]  frwrd
);

  // Command handshake: cmd is valid while cmd_rdy is high and stays valid until the
  // consumer pulses clr_cmd_rdy. A command is taken only in IDLE; clr_cmd_rdy pulses the
  // cycle after it is taken, and that cycle is masked so a still-high cmd_rdy is not
  // taken twice. send_resp pulses once when the command's work is complete.

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HEADING   = 2'd1;
  localparam logic [1:0] RAMP_UP   = 2'd2;
  localparam logic [1:0] RAMP_DOWN = 2'd3;

  localparam logic [3:0] OP_MOVE = 4'h2;

`ifdef MOVE_CMD_FAST_SIM_EN
  localparam logic [9:0] STEP_UP = FRWRD_INC << 3;
  localparam logic [9:0] STEP_DN = FRWRD_INC << 4;
`else
  localparam logic [9:0] STEP_UP = FRWRD_INC;
  localparam logic [9:0] STEP_DN = FRWRD_INC << 1;
`endif

  logic [1:0]  state;
  logic [11:0] cmd_q;
  logic [4:0]  line_cnt;
  logic        cntr_q;

  logic [11:0] desired_hdg;
  logic [11:0] err_comb;
  logic [11:0] err_abs;
  logic        aligned;
  logic        cntr_rise;
  logic        cmd_take;
  logic [4:0]  line_target;
  logic [10:0] ramp_sum;
  logic [9:0]  frwrd_up;
  logic [9:0]  frwrd_dn;

  // Heading code 0 means "due north" exactly; otherwise point at the top of the code's bin.
  assign desired_hdg = (cmd_q[11:4] != 8'h00) ? {cmd_q[11:4], 4'hF} : 12'h000;
  assign err_comb    = heading - desired_hdg;
  assign err_abs     = err_comb[11] ? (12'h000 - err_comb) : err_comb;
  assign aligned     = (err_abs < ERR_TOL);

  assign cntr_rise   = cntrIR & ~cntr_q;
  assign cmd_take    = cmd_rdy & ~clr_cmd_rdy;
  assign line_target = {cmd_q[3:0], 1'b0};

  assign ramp_sum = {1'b0, frwrd} + {1'b0, STEP_UP};
  assign frwrd_up = (ramp_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : ramp_sum[9:0];
  assign frwrd_dn = (frwrd > STEP_DN) ? (frwrd - STEP_DN) : 10'd0;

  assign moving = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_q       <= 12'h000;
      line_cnt    <= 5'd0;
      cntr_q      <= 1'b0;
      frwrd       <= 10'd0;
      error       <= 12'h000;
      err_vld     <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
    end else begin
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      err_vld     <= heading_rdy;
      cntr_q      <= cntrIR;
      // The PID always sees live error, whatever the sequencer is doing.
      if (heading_rdy) begin
        error <= err_comb;
      end

      case (state)
        IDLE: begin
          frwrd <= 10'd0;
          if (cmd_take) begin
            cmd_q       <= cmd[11:0];
            clr_cmd_rdy <= 1'b1;
            if (cmd[15:12] == OP_MOVE) begin
              state <= HEADING;
            end else begin
              send_resp <= 1'b1;
            end
          end
        end

        HEADING: begin
          if (heading_rdy && aligned) begin
            state <= RAMP_UP;
          end
        end

        RAMP_UP: begin
          // Reaching the target takes priority, so zero squares leaves frwrd untouched.
          if (line_cnt == line_target) begin
            state <= RAMP_DOWN;
          end else begin
            if (heading_rdy) begin
              frwrd <= frwrd_up;
            end
            if (cntr_rise) begin
              line_cnt <= line_cnt + 5'd1;
            end
          end
        end

        RAMP_DOWN: begin
          if (frwrd == 10'd0) begin
            send_resp <= 1'b1;
            line_cnt  <= 5'd0;
            state     <= IDLE;
          end else if (heading_rdy) begin
            frwrd <= frwrd_dn;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_cmd_gen.sv
// Bench for move_cmd_gen: directed move scenarios plus randomized moves, every cycle
// compared against a behavioural model of the command sequencer.
module tb_move_cmd_gen;

`ifdef MOVE_CMD_FAST_SIM_EN
  localparam int STEP_UP = 16 * 8;
  localparam int STEP_DN = 16 * 16;
`else
  localparam int STEP_UP = 16;
  localparam int STEP_DN = 32;
`endif
  localparam int FMAX = 768;
  localparam int TOL  = 48;

  localparam int PH_IDLE = 0;
  localparam int PH_HEAD = 1;
  localparam int PH_UP   = 2;
  localparam int PH_DOWN = 3;

  logic        clk;
  logic        rst;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        cntrIR;
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;

  move_cmd_gen dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .heading     (heading),
    .heading_rdy (heading_rdy),
    .cntrIR      (cntrIR),
    .moving      (moving),
    .err_vld     (err_vld),
    .error       (error),
    .frwrd       (frwrd)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard: {moving, err_vld, error, frwrd, clr_cmd_rdy, send_resp}
  logic [25:0] exp_q[$];
  int n_cmp;
  int n_err;

  // bookkeeping from observed outputs
  bit drop_pending;
  bit send_seen;
  int clr_cnt;
  int clr_at_send;
  int frwrd_peak;

  // behavioural model state
  int m_phase;
  int m_cmd;
  int m_lines;
  int m_frwrd;
  int m_error;
  bit m_err_vld;
  bit m_clr;
  bit m_send;
  bit m_prev_ir;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_cmd     = 0;
    m_lines   = 0;
    m_frwrd   = 0;
    m_error   = 0;
    m_err_vld = 0;
    m_clr     = 0;
    m_send    = 0;
    m_prev_ir = 0;
  endtask

  // Predict the outputs after the coming clock edge from the inputs now applied.
  task automatic model_step();
    int  code;
    int  desired;
    int  diff;
    int  sdiff;
    int  squares;
    bit  rise;
    bit  old_clr;
    code    = (m_cmd >> 4) & 255;
    desired = (code != 0) ? code * 16 + 15 : 0;
    diff    = (int'(heading) - desired) & 4095;
    sdiff   = (diff >= 2048) ? diff - 4096 : diff;
    squares = m_cmd & 15;
    rise    = cntrIR && !m_prev_ir;
    old_clr = m_clr;
    m_clr   = 0;
    m_send  = 0;
    case (m_phase)
      PH_IDLE: begin
        m_frwrd = 0;
        if (cmd_rdy && !old_clr) begin
          m_cmd = int'(cmd);
          m_clr = 1;
          if (cmd[15:12] == 4'h2) m_phase = PH_HEAD;
          else m_send = 1;
        end
      end
      PH_HEAD: begin
        if (heading_rdy && sdiff < TOL && sdiff > -TOL) m_phase = PH_UP;
      end
      PH_UP: begin
        if (m_lines == 2 * squares) begin
          m_phase = PH_DOWN;
        end else begin
          if (heading_rdy) m_frwrd = (m_frwrd + STEP_UP > FMAX) ? FMAX : m_frwrd + STEP_UP;
          if (rise) m_lines++;
        end
      end
      default: begin
        if (m_frwrd == 0) begin
          m_send  = 1;
          m_lines = 0;
          m_phase = PH_IDLE;
        end else if (heading_rdy) begin
          m_frwrd = (m_frwrd > STEP_DN) ? m_frwrd - STEP_DN : 0;
        end
      end
    endcase
    if (heading_rdy) m_error = diff;
    m_err_vld = heading_rdy;
    m_prev_ir = cntrIR;
    exp_q.push_back({m_phase != PH_IDLE, m_err_vld, 12'(m_error), 10'(m_frwrd), m_clr, m_send});
  endtask

  task automatic compare_outputs();
    logic [25:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("moving", moving, e[25]);
      check_eq("err_vld", err_vld, e[24]);
      check_eq("error", error, e[23:12]);
      check_eq("frwrd", frwrd, e[11:2]);
      check_eq("clr_cmd_rdy", clr_cmd_rdy, e[1]);
      check_eq("send_resp", send_resp, e[0]);
    end
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
    if (send_resp) begin
      send_seen   = 1;
      clr_at_send = clr_cnt;
    end
    if (clr_cmd_rdy) clr_cnt++;
    if (int'(frwrd) > frwrd_peak) frwrd_peak = int'(frwrd);
    // The command source drops cmd_rdy one cycle after it sees clr_cmd_rdy.
    if (drop_pending) begin
      cmd_rdy      = 1'b0;
      drop_pending = 0;
    end
    if (clr_cmd_rdy) drop_pending = 1;
  endtask

  task automatic issue_cmd(input logic [15:0] c);
    bit taken;
    taken   = 0;
    cmd     = c;
    cmd_rdy = 1'b1;
    for (int i = 0; i < 10 && !taken; i++) begin
      tick();
      if (clr_cmd_rdy) taken = 1;
    end
    check_eq("cmd_taken", taken, 1);
  endtask

  task automatic hdg_pulse(input logic [11:0] h);
    heading     = h;
    heading_rdy = 1'b1;
    tick();
    heading_rdy = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic ir_rise();
    cntrIR = 1'b1;
    repeat ($urandom_range(1, 3)) tick();
    cntrIR = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic finish_move(input logic [11:0] h, output int n);
    send_seen = 0;
    n = 0;
    for (int i = 0; i < 200 && !send_seen; i++) begin
      if (frwrd != 10'd0) n++;
      hdg_pulse(h);
    end
    check_eq("move_done", send_seen, 1);
  endtask

  // main sequence
  initial begin
    int n;
    int clr_before;
    bit got_clr;
    logic [7:0] code;
    logic [3:0] sq;
    int desired;

    rst = 1'b1; cmd = 16'h0000; cmd_rdy = 1'b0;
    heading = 12'h000; heading_rdy = 1'b0; cntrIR = 1'b0;
    n_cmp = 0; n_err = 0; drop_pending = 0; send_seen = 0;
    clr_cnt = 0; clr_at_send = 0; frwrd_peak = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_moving", moving, 0);
    check_eq("rst_frwrd", frwrd, 0);
    check_eq("rst_err_vld", err_vld, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_clr", clr_cmd_rdy, 0);
    check_eq("rst_send", send_resp, 0);
    rst = 1'b0;
    tick();
    tick();

    // err_vld latency with desired heading 0
    heading = 12'h100; heading_rdy = 1'b1;
    tick();
    heading_rdy = 1'b0;
    check_eq("lat_vld_n1", err_vld, 1);
    check_eq("lat_err_n1", error, 12'h100);
    tick();
    check_eq("lat_vld_n2", err_vld, 0);

    // async reset in the middle of a ramp-up
    issue_cmd(16'h2001);
    hdg_pulse(12'h010);
    repeat (8) hdg_pulse(12'h010);
    check_eq("pre_rst_frwrd", frwrd, (8 * STEP_UP > FMAX) ? FMAX : 8 * STEP_UP);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_frwrd", frwrd, 0);
    check_eq("arst_moving", moving, 0);
    check_eq("arst_err_vld", err_vld, 0);
    check_eq("arst_error", error, 0);
    model_reset();
    exp_q.delete();
    drop_pending = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check_eq("post_rst_frwrd", frwrd, 0);
    check_eq("post_rst_moving", moving, 0);

    // align then ramp
    issue_cmd(16'h2001);
    check_eq("move_moving", moving, 1);
    hdg_pulse(12'h0C0);
    check_eq("misaligned_frwrd", frwrd, 0);
    hdg_pulse(12'h010);
    repeat (16) hdg_pulse(12'h010);
    check_eq("ramp16_frwrd", frwrd, (16 * STEP_UP > FMAX) ? FMAX : 16 * STEP_UP);
    ir_rise();
    ir_rise();
    finish_move(12'h010, n);
    check_eq("move1_idle", moving, 0);

    // wrap-around heading, saturation, full ramp-down
    issue_cmd(16'h2FF1);
    hdg_pulse(12'h001);
    check_eq("wrap_err", error, 12'h002);
    repeat (60) hdg_pulse(12'h001);
    check_eq("sat_frwrd", frwrd, FMAX);
    ir_rise();
    ir_rise();
    finish_move(12'h001, n);
    check_eq("down_pulses", n, (FMAX + STEP_DN - 1) / STEP_DN);
    check_eq("wrap_idle", moving, 0);

    // unsupported opcode
    issue_cmd(16'h5123);
    check_eq("unsup_send", send_resp, 1);
    check_eq("unsup_moving", moving, 0);
    tick();
    tick();
    check_eq("unsup_still_idle", moving, 0);

    // busy: a held command is not taken until the running move completes
    issue_cmd(16'h2003);
    hdg_pulse(12'h005);
    repeat (4) hdg_pulse(12'h005);
    cmd = 16'h2000;
    cmd_rdy = 1'b1;
    clr_before = clr_cnt;
    repeat (6) begin
      ir_rise();
      hdg_pulse(12'h005);
    end
    finish_move(12'h005, n);
    check_eq("busy_no_clr", clr_at_send - clr_before, 0);
    got_clr = (clr_cnt > clr_at_send);
    for (int i = 0; i < 10 && !got_clr; i++) begin
      tick();
      got_clr = (clr_cnt > clr_at_send);
    end
    check_eq("busy_clr_after_idle", got_clr, 1);
    frwrd_peak = 0;
    finish_move(12'h003, n);
    check_eq("zero_sq_peak", frwrd_peak, 0);

    // randomized moves
    for (int mv = 0; mv < 10; mv++) begin
      code    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      sq      = 4'($urandom_range(0, 3));
      desired = (code != 8'h00) ? int'(code) * 16 + 15 : 0;
      issue_cmd({4'h2, code, sq});
      send_seen = 0;
      for (int c = 0; c < 4000 && !send_seen; c++) begin
        heading_rdy = ($urandom_range(0, 2) == 0);
        heading     = 12'(desired + int'($urandom_range(0, 160)) - 80);
        if ($urandom_range(0, 7) == 0) cntrIR = ~cntrIR;
        tick();
      end
      heading_rdy = 1'b0;
      cntrIR = 1'b0;
      tick();
      tick();
      check_eq("rand_done", send_seen, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/move_cmd_gen.md
Name: move_cmd_gen

Overview:
- Command-side counterpart of the PID block: turns a 16-bit move command and the inertial heading stream into the PID's `moving` / `err_vld` / `error` / `frwrd` inputs.
- Sequences a move: align heading, ramp forward speed up, count squares via the centre IR line sensor, then ramp down.
- Sits between the UART command path (`cmd`/`cmd_rdy`) and the PID.

Parameters:
- ERR_TOL, 12'h030, heading error magnitude below which the heading counts as aligned.
- FRWRD_INC, 10'h010, frwrd increment per heading_rdy during ramp-up; ramp-down step is 2*FRWRD_INC.
- FRWRD_MAX, 10'h300, saturation ceiling for frwrd.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd  in  16  [15:12] opcode (4'h2 = move), [11:4] heading code, [3:0] squares.
- cmd_rdy  in  1  command valid; held until cleared.
- clr_cmd_rdy  out  1  one-cycle pulse: command consumed.
- send_resp  out  1  one-cycle pulse: command complete.
- heading  in  12  signed current heading from inertial interface.
- heading_rdy  in  1  one-cycle pulse: new heading valid.
- cntrIR  in  1  centre IR line sensor, already synchronized.
- moving  out  1  to PID; high in every state except IDLE.
- err_vld  out  1  to PID; heading_rdy delayed one cycle.
- error  out  12  to PID; signed heading error, registered.
- frwrd  out  10  to PID; unsigned forward speed, registered.

Behaviour:
- Reset (async, any time, mid-move included): state=IDLE; frwrd, error, err_vld, moving, clr_cmd_rdy, send_resp, line count and latched cmd all 0.
- Desired heading: {cmd[11:4],4'hF} if cmd[11:4]!=0, else 12'h000. Latched when the command is accepted.
- Error: error = heading - desired_heading, 12-bit modular (wrap, no saturation). Registered on heading_rdy; err_vld pulses in the same cycle error updates (latency 1 from heading_rdy).
- Aligned: |error_comb| < ERR_TOL, using the unregistered difference at the heading_rdy cycle.
- IDLE:
  - moving=0, frwrd=0.
  - On cmd_rdy: latch cmd and pulse clr_cmd_rdy next cycle.
  - Opcode 4'h2: go to HEADING.
  - Any other opcode: pulse send_resp together with clr_cmd_rdy; stay IDLE.
- HEADING: frwrd held 0. On a heading_rdy cycle that is aligned, go to RAMP_UP.
- RAMP_UP:
  - Each heading_rdy: frwrd = min(frwrd+FRWRD_INC, FRWRD_MAX).
  - A cntrIR rising edge (registered edge detect) increments the line count.
  - When line count == 2*squares, go to RAMP_DOWN.
  - squares=0: go to RAMP_DOWN on the first RAMP_UP cycle, with frwrd still 0.
- RAMP_DOWN:
  - Each heading_rdy: frwrd = frwrd - 2*FRWRD_INC, floored at 0.
  - When frwrd==0: pulse send_resp, clear line count, go to IDLE.
  - cntrIR edges are ignored.
- Simultaneous events:
  - heading_rdy and a cntrIR edge in the same cycle: both take effect; the frwrd increment uses the pre-transition state.
  - cmd_rdy outside IDLE: ignored, no clr_cmd_rdy.
- error/err_vld keep updating in every state, IDLE included, so the PID sees live error.

Optional Feature:
- Macro: MOVE_CMD_FAST_SIM_EN.
- Defined: ramp-up step is FRWRD_INC<<3 and ramp-down step is FRWRD_INC<<4, both still saturating/flooring, for short full-chip sims.
- Undefined: steps as specified above.

Test Plan:
- Reset check: assert rst mid-RAMP_UP with frwrd=10'h080 -> same cycle frwrd=0, moving=0, err_vld=0, state IDLE; first clk edge after release changes nothing.
- Align then ramp: cmd=16'h2001, cmd_rdy=1 -> clr_cmd_rdy pulse, moving=1.
  - heading=12'h0C0 (error 0x0C0): stays in HEADING.
  - heading=12'h010: enters RAMP_UP.
  - 16 further heading_rdy -> frwrd=10'h100.
- Wrap and reverse ramp:
  - cmd=16'h2FF1 gives desired 12'hFFF; heading=12'h001 -> error=12'h002, aligned.
  - 60 heading_rdy -> frwrd saturates at 10'h300.
  - Two cntrIR rises -> 24 heading_rdy to frwrd=0, then send_resp pulse, IDLE.
- Unsupported opcode: cmd=16'h5123 -> clr_cmd_rdy and send_resp in the same cycle; moving stays 0.
- Busy / zero squares: cmd_rdy held during RAMP_UP -> no clr_cmd_rdy until IDLE. Then cmd=16'h2000, aligned -> send_resp with frwrd never leaving 0.
- err_vld latency: heading_rdy at cycle N with heading=12'h100, desired 12'h000 -> err_vld=1 and error=12'h100 at cycle N+1 only.
